// File: rtl/sfx_note_sequencer.sv
// Buzzer note scheduler: looping background music with prioritised jump/coin/crash sound effects.
// Latency: a request or bgm_en rise shows its first note on the outputs one clk after it is sampled.
// Backpressure: none; losing or lower-priority requests are dropped, never queued.
module sfx_note_sequencer #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bgm_en,
  input  logic [2:0]  sfx_req,
  output logic [21:0] note_div,
  output logic        note_valid,
  output logic [1:0]  active_id,
  output logic        sfx_busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, BGM, SFX} state_t;

  state_t          state;
  logic [1:0]      bgm_idx;
  logic [1:0]      sfx_idx;
  logic [TW-1:0]   tick_cnt;
  logic [1:0]      dur_cnt;

  logic [1:0]      req_id;
  logic            req_take;
  logic [1:0]      cur_dur;
  logic            tick_last;
  logic            note_end;
  logic            sfx_last;

  // Note tables, id 0 is the background loop; a zero divider is a rest.
  function automatic logic [21:0] div_rom(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: div_rom = 22'd95601;
      4'b00_01: div_rom = 22'd75871;
      4'b00_10: div_rom = 22'd63774;
      4'b00_11: div_rom = 22'd75871;
      4'b01_00: div_rom = 22'd37907;
      4'b01_01: div_rom = 22'd31887;
      4'b10_00: div_rom = 22'd50606;
      4'b10_01: div_rom = 22'd37907;
      4'b11_00: div_rom = 22'd190838;
      4'b11_10: div_rom = 22'd190838;
      default:  div_rom = 22'd0;
    endcase
  endfunction

  // Note durations in ticks, indexed like div_rom.
  function automatic logic [1:0] dur_rom(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b01_00, 4'b01_01, 4'b10_00, 4'b11_01, 4'b11_11: dur_rom = 2'd1;
      4'b10_01:                                          dur_rom = 2'd3;
      default:                                           dur_rom = 2'd2;
    endcase
  endfunction

  // Priority encode the request pulses: crash > coin > jump.
  always_comb begin
    req_id = 2'd0;
    if (sfx_req[2])      req_id = 2'd3;
    else if (sfx_req[1]) req_id = 2'd2;
    else if (sfx_req[0]) req_id = 2'd1;
  end

  assign req_take  = (req_id != 2'd0) && ((state != SFX) || (req_id >= active_id));
  assign cur_dur   = (state == SFX) ? dur_rom(active_id, sfx_idx) : dur_rom(2'd0, bgm_idx);
  assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
  assign note_end  = tick_last && (dur_cnt == cur_dur - 2'd1);
  assign sfx_last  = (sfx_idx == ((active_id == 2'd3) ? 2'd3 : 2'd1));

  // Sequencer FSM: request acceptance, note stepping, timing counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bgm_idx    <= 2'd0;
      sfx_idx    <= 2'd0;
      tick_cnt   <= '0;
      dur_cnt    <= 2'd0;
      note_div   <= 22'd0;
      note_valid <= 1'b0;
      active_id  <= 2'd0;
      sfx_busy   <= 1'b0;
    end else begin
      // Losing the enable always rewinds the loop, even while an effect plays.
      if (!bgm_en) bgm_idx <= 2'd0;

      if (req_take) begin
        state      <= SFX;
        active_id  <= req_id;
        sfx_busy   <= 1'b1;
        sfx_idx    <= 2'd0;
        note_div   <= div_rom(req_id, 2'd0);
        note_valid <= 1'b1;
        tick_cnt   <= '0;
        dur_cnt    <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            dur_cnt  <= 2'd0;
            if (bgm_en) begin
              state      <= BGM;
              note_div   <= div_rom(2'd0, bgm_idx);
              note_valid <= 1'b1;
            end
          end
          BGM: begin
            if (!bgm_en) begin
              state      <= IDLE;
              note_div   <= 22'd0;
              note_valid <= 1'b0;
              tick_cnt   <= '0;
              dur_cnt    <= 2'd0;
            end else if (note_end) begin
              bgm_idx    <= bgm_idx + 2'd1;
              note_div   <= div_rom(2'd0, bgm_idx + 2'd1);
              note_valid <= 1'b1;
              tick_cnt   <= '0;
              dur_cnt    <= 2'd0;
            end else if (tick_last) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + 2'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          SFX: begin
            if (note_end) begin
              tick_cnt <= '0;
              dur_cnt  <= 2'd0;
              if (!sfx_last) begin
                sfx_idx    <= sfx_idx + 2'd1;
                note_div   <= div_rom(active_id, sfx_idx + 2'd1);
                note_valid <= (div_rom(active_id, sfx_idx + 2'd1) != 22'd0);
              end else if (bgm_en) begin
                // Resume the loop at the frozen index with a fresh full note.
                state      <= BGM;
                active_id  <= 2'd0;
                sfx_busy   <= 1'b0;
                sfx_idx    <= 2'd0;
                note_div   <= div_rom(2'd0, bgm_idx);
                note_valid <= 1'b1;
              end else begin
                state      <= IDLE;
                active_id  <= 2'd0;
                sfx_busy   <= 1'b0;
                sfx_idx    <= 2'd0;
                note_div   <= 22'd0;
                note_valid <= 1'b0;
              end
            end else if (tick_last) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt + 2'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
